// File: rtl/pipe_stage_if.sv
// pipe_stage_if: handshake, flush and occupancy bundle between a pipeline stage and its neighbours
interface pipe_stage_if #(
  parameter int WIDTH = 32
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0] occ;
  modport master(output flush, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, occ);
  modport slave(input flush, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, occ);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input logic clk,
  input logic rst,
  pipe_stage_if.slave bus
);
  logic main_v;
  logic [WIDTH-1:0] main_d;
  logic acc;
  logic main_ld;
  assign acc = bus.in_valid && bus.in_ready;
  assign main_ld = !main_v || bus.out_ready;
  assign bus.out_valid = main_v;
  assign bus.out_data = main_d;
`ifdef PIPE_STAGE_SKID_EN
  logic skid_v;
  logic [WIDTH-1:0] skid_d;
  assign bus.in_ready = !skid_v && !rst;
  assign bus.occ = {1'b0, main_v} + {1'b0, skid_v};
  // main refills from skid first to keep order; skid catches a payload accepted while main is stalled
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      main_v <= 1'b0;
      main_d <= CLEAR_VAL;
      skid_v <= 1'b0;
      skid_d <= CLEAR_VAL;
    end else begin
      if (main_ld) begin
        main_v <= skid_v || acc;
        main_d <= skid_v ? skid_d : acc ? bus.in_data : main_d;
        skid_v <= 1'b0;
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_d <= bus.in_data;
      end
    end
`else
  assign bus.in_ready = !rst && (!main_v || bus.out_ready);
  assign bus.occ = {1'b0, main_v};
  // single entry: refill whenever the current payload leaves or the stage is empty
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      main_v <= 1'b0;
      main_d <= CLEAR_VAL;
    end else if (main_ld) begin
      main_v <= acc;
      main_d <= acc ? bus.in_data : main_d;
    end
`endif
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, flush and an optional two-entry skid buffer. It is the generic replacement for the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Control and datapath fields are packed into one payload vector, which is cleared to a programmable value on reset or flush. Backpressure (stall) travels through in_ready/out_ready, so the hazard unit drives out_ready instead of gating clocks.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- CLEAR_VAL, '0 (WIDTH bits): payload value after reset and after flush. The control bits used by decode are all zero here, which makes it a NOP/bubble.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill every held entry; the stage is empty on the next cycle.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts this cycle (deasserted by the hazard unit to stall).
- out_data  out  WIDTH  payload presented downstream.
- occ  out  2  number of entries held (0..2; max 1 without skid).

## Operation
- Accept: in_valid & in_ready at an edge. Emit: out_valid & out_ready at an edge.
- Main entry (main_v, main_d) always drives out_valid/out_data.
- Main loads when !main_v or out_ready:
  - if the skid entry is valid, main takes the skid entry;
  - else main takes in_data if accepted;
  - else main_v clears and main_d holds its value.
- Skid entry (PIPE_STAGE_SKID_EN only): loads in_data when a payload is accepted while main_v & !out_ready. It clears when it moves into main.
- Priority: rst > flush > normal. On flush, both entries become invalid and both payloads take CLEAR_VAL. A payload accepted in the flush cycle is discarded: the upstream handshake completes but the data is dropped.
- Order is preserved. No payload is duplicated or lost except by flush.
- occ equals main_v + skid_v, registered.

## Timing
- Reset values: out_valid=0, out_data=CLEAR_VAL, occ=0, in_ready=0 while rst=1. in_ready=1 on the first cycle after rst deasserts.
- Latency: 1 cycle from accept to out_valid for an empty stage.
- Throughput: 1 payload/cycle while out_ready=1.
- With skid: in_ready = !skid_v, driven directly from a flop, so there is no combinational path from out_ready to in_ready.
- Without skid: in_ready = !main_v | out_ready, a combinational path.
- Stall: with out_ready=0, out_data and out_valid stay stable until they are emitted.
- Full (skid mode, occ=2): in_ready=0. In that cycle out_ready=1 moves the skid entry to main, and in_ready=1 the following cycle.
- Flush and out_ready=1 in the same cycle: the current out_data still counts as emitted, because the downstream handshake is valid. On the next cycle out_valid=0.
- Flush while stalled: out_valid=0 and occ=0 next cycle, regardless of out_ready.
- rst asserted mid-stream: same effect as flush, plus in_ready=0 during reset.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer and registered in_ready. Full throughput with no ready path through the stage. occ ranges 0..2.
- Undefined: single entry with combinational in_ready. occ ranges 0..1. There are no skid flops, and occ[1] ties to 0.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid=1 and in_data=0xDEADBEEF. Required: out_valid=0, out_data=CLEAR_VAL, in_ready=0 throughout reset. After release, in_ready=1 and out_valid=0.
- Streaming: send 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1. Required: out_data is 0x1..0x4 on cycles 1..4 after the first accept, one per cycle, with no gaps.
- Stall with skid: send 0xA, 0xB, 0xC and drop out_ready after 0xA appears. Required:
  - 0xA is held at the output;
  - 0xB is accepted and occ=2;
  - in_ready=0, so 0xC is held upstream;
  - after out_ready rises, the output sequence is 0xA,0xB,0xC.
  - Without PIPE_STAGE_SKID_EN: 0xB is not accepted while stalled, occ=1, and the order is the same.
- Flush while full (occ=2): assert flush for 1 cycle. Required next cycle: out_valid=0, out_data=CLEAR_VAL, occ=0, in_ready=1. A payload 0x55 offered in the flush cycle never appears at the output.
- Flush concurrent with emit: out_valid=1, out_data=0x77, out_ready=1 and flush=1 in the same cycle. Required: 0x77 is counted as emitted exactly once, with out_valid=0 next cycle.
- Back-to-back stall toggle: toggle out_ready every cycle over a 16-payload stream (0..15). Required: downstream receives 0..15 in order with no duplicate, and occ never exceeds 2 (skid mode) or 1 (without skid).
